// File: rtl/mac_mul_pkg.sv
// Shared definitions for the pipelined multi-precision MAC multiplier:
// cfg encodings, active-slice decoding and the lane product width.
package mac_mul_pkg;

    localparam logic [2:0] MAC_CFG_SINGLE = 3'b000;
    localparam logic [2:0] MAC_CFG_DUAL   = 3'b001;
    localparam logic [2:0] MAC_CFG_QUAD   = 3'b010;

    localparam int MAC_DEF_MIN_WIDTH   = 8;
    localparam int MAC_LANE_PROD_WIDTH = 2 * MAC_DEF_MIN_WIDTH;

    function automatic int lane_prod_width(input int w);
        return 2 * w;
    endfunction

    // Number of A slices a cfg code uses; 0 marks an illegal code.
    function automatic int slice_count(input logic [31:0] cfg);
        case (cfg)
            32'(MAC_CFG_SINGLE): return 1;
            32'(MAC_CFG_DUAL):   return 2;
            32'(MAC_CFG_QUAD):   return 4;
            default:             return 0;
        endcase
    endfunction

endpackage

// File: rtl/mac_mul_combine.sv
// Combinational carry-chain combiner: adds lane product i at offset i*W and
// flags illegal cfg codes (result forced to zero).
module mac_mul_combine
    import mac_mul_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int NUM_LANES      = 4,
    parameter int MAC_INT_WIDTH  = (NUM_LANES + 1) * MAC_MIN_WIDTH
) (
    input  logic [NUM_LANES*lane_prod_width(MAC_MIN_WIDTH)-1:0] lane_prod,
    input  logic [MAC_CONF_WIDTH-1:0]                           cfg,
    input  logic                                                sgn,
    output logic [MAC_INT_WIDTH-1:0]                            C,
    output logic                                                err
);

    localparam int PW = lane_prod_width(MAC_MIN_WIDTH);

    int                       n_active;
    logic [MAC_INT_WIDTH-1:0] acc [NUM_LANES+1];

    assign n_active = slice_count(32'(cfg));
    assign acc[0]   = '0;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_chain
            logic signed [PW-1:0]       prod;
            logic [MAC_INT_WIDTH-1:0]   prod_ext;

            assign prod = lane_prod[gi*PW +: PW];
            // Signed transactions carry two's-complement lane products.
            assign prod_ext = sgn ? MAC_INT_WIDTH'(prod)
                                  : MAC_INT_WIDTH'(lane_prod[gi*PW +: PW]);
            assign acc[gi+1] = acc[gi] + (prod_ext << (gi * MAC_MIN_WIDTH));
        end
    endgenerate

    assign err = (n_active == 0) || (n_active > NUM_LANES);
    assign C   = err ? '0 : acc[NUM_LANES];

endmodule

// File: rtl/mac_mul_pipe.sv
// Two-stage valid/ready multiplier: S1 lane products, S2 carry-chain combine.
// Optional MAC_MUL_SIGNED_EN adds a per-transaction sgn input (two's complement).
module mac_mul_pipe
    import mac_mul_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int NUM_LANES      = 4,
    parameter int MAC_INT_WIDTH  = (NUM_LANES + 1) * MAC_MIN_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] A,
    input  logic [MAC_MIN_WIDTH-1:0]          B,
    input  logic [MAC_CONF_WIDTH-1:0]         cfg,
`ifdef MAC_MUL_SIGNED_EN
    input  logic                              sgn,
`endif
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MAC_INT_WIDTH-1:0]          C,
    output logic                              out_err
);

    localparam int W  = MAC_MIN_WIDTH;
    localparam int PW = lane_prod_width(MAC_MIN_WIDTH);

    logic                        sgn_in;
    int                          n_in;
    logic [NUM_LANES*PW-1:0]     prod_next;
    logic                        s2_load;
    logic                        accept;

    logic                        s1_valid_reg;
    logic [NUM_LANES*PW-1:0]     s1_prod_reg;
    logic [MAC_CONF_WIDTH-1:0]   s1_cfg_reg;
    logic                        s1_sgn_reg;

    logic                        out_valid_reg;
    logic [MAC_INT_WIDTH-1:0]    c_reg;
    logic                        err_reg;
    logic [MAC_INT_WIDTH-1:0]    c_next;
    logic                        err_next;

`ifdef MAC_MUL_SIGNED_EN
    assign sgn_in = sgn;
`else
    assign sgn_in = 1'b0;
`endif

    assign n_in     = slice_count(32'(cfg));
    assign s2_load  = en & (~out_valid_reg | out_ready);
    assign in_ready = en & ~rst & (~s1_valid_reg | s2_load);
    assign accept   = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [W-1:0]  a_slice;
            logic          a_sign;
            logic          b_sign;
            logic [PW-1:0] a_ext;
            logic [PW-1:0] b_ext;

            // Slices beyond the active count are zeroed before the multiply.
            assign a_slice = (gi < n_in) ? A[gi*W +: W] : '0;
            assign a_sign  = sgn_in & (gi == n_in - 1) & a_slice[W-1];
            assign b_sign  = sgn_in & B[W-1];
            assign a_ext   = {{W{a_sign}}, a_slice};
            assign b_ext   = {{W{b_sign}}, B};
            // Low 2W bits of the extended product are exact for both signednesses.
            assign prod_next[gi*PW +: PW] = a_ext * b_ext;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (en && (!s1_valid_reg || s2_load)) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_prod_reg <= prod_next;
                s1_cfg_reg  <= cfg;
                s1_sgn_reg  <= sgn_in;
            end
        end
    end

    mac_mul_combine #(
        .MAC_CONF_WIDTH (MAC_CONF_WIDTH),
        .MAC_MIN_WIDTH  (MAC_MIN_WIDTH),
        .NUM_LANES      (NUM_LANES),
        .MAC_INT_WIDTH  (MAC_INT_WIDTH)
    ) u_combine (
        .lane_prod (s1_prod_reg),
        .cfg       (s1_cfg_reg),
        .sgn       (s1_sgn_reg),
        .C         (c_next),
        .err       (err_next)
    );

    // Result register holds C/out_err whenever the stage does not load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            c_reg         <= '0;
            err_reg       <= 1'b0;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                c_reg   <= c_next;
                err_reg <= err_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign C         = c_reg;
    assign out_err   = err_reg;

endmodule

// File: tb/tb_mac_mul_pipe.sv
// Self-checking bench for mac_mul_pipe: directed vectors plus randomized
// streams scored against an arithmetic reference model.
module tb_mac_mul_pipe;

    localparam int L   = 4;
    localparam int W   = 8;
    localparam int INT = (L + 1) * W;

    typedef struct {
        logic [INT-1:0] c;
        logic           err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst, en, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [L*W-1:0] A;
    logic [W-1:0]   B;
    logic [2:0]     cfg;
    logic           sgn;
    logic [INT-1:0] C;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    bit   held = 1'b0;
    logic [INT-1:0] held_c;
    logic           held_err;

    always #5 clk = ~clk;

    mac_mul_pipe #(
        .MAC_CONF_WIDTH (3),
        .MAC_MIN_WIDTH  (W),
        .NUM_LANES      (L),
        .MAC_INT_WIDTH  (INT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cfg       (cfg),
`ifdef MAC_MUL_SIGNED_EN
        .sgn       (sgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: mask A to the active slices, multiply as integers, truncate.
    function automatic exp_t model(input logic [31:0] a, input logic [7:0] b,
                                   input logic [2:0] c, input bit s);
        exp_t   e;
        int     n;
        int     aw;
        longint av, bv, p;
        case (c)
            3'd0:    n = 1;
            3'd1:    n = 2;
            3'd2:    n = 4;
            default: n = 0;
        endcase
        if (n == 0 || n > L) begin
            e.c = '0;
            e.err = 1'b1;
            return e;
        end
        aw = n * W;
        av = longint'(a) & ((64'sd1 << aw) - 1);
        bv = longint'(b);
        if (s) begin
            if (av >= (64'sd1 << (aw - 1))) av -= (64'sd1 << aw);
            if (bv >= 128) bv -= 256;
        end
        p = av * bv;
        e.c = p[INT-1:0];
        e.err = 1'b0;
        return e;
    endfunction

    // One clock: check handshake/hold rules, score output, record input.
    task automatic step(output bit accepted);
        exp_t e;
        bit   acc_out;
        #1;
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
        end else begin
            check("in_ready", in_ready, 64'(en && !(q.size() == 2 && !out_ready)));
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_c", C, held_c);
                check("hold_err", out_err, held_err);
            end
            if (q.size() == 0) check("idle_valid", out_valid, 0);
        end
        accepted = !rst && en && in_valid && in_ready;
        acc_out  = !rst && en && out_valid && out_ready;
        if (acc_out) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                check("out_c", C, e.c);
                check("out_err", out_err, e.err);
            end
        end
        if (accepted) q.push_back(model(A, B, cfg, sgn));
        held     = !rst && out_valid && (!out_ready || !en);
        held_c   = C;
        held_err = out_err;
        @(posedge clk);
        if (rst) q.delete();
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        int guard = 0;
        in_valid = 1'b0;
        while (q.size() > 0 && guard < 50) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            guard++;
        end
        check("drain_left", q.size(), 0);
        out_ready = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [7:0] b,
                        input logic [2:0] c, input bit s);
        bit acc = 1'b0;
        int guard = 0;
        A = a; B = b; cfg = c; sgn = s; in_valid = 1'b1;
        while (!acc && guard < 20) begin
            step(acc);
            guard++;
        end
        check("send_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    // Sends one transaction, waits for it with out_ready low, checks literals.
    task automatic directed(input string tag, input logic [31:0] a, input logic [7:0] b,
                            input logic [2:0] c, input bit s,
                            input logic [INT-1:0] ec, input logic ee);
        bit acc;
        int guard = 0;
        out_ready = 1'b0;
        send(a, b, c, s);
        while (!out_valid && guard < 10) begin
            step(acc);
            guard++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_c"}, C, 64'(ec));
        check({tag, "_err"}, out_err, 64'(ee));
        out_ready = 1'b1;
        step(acc);
    endtask

    initial begin
        bit acc;
        int sent, guard;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; cfg = 3'd0; sgn = 1'b0;
        @(negedge clk);
        step(acc);
        step(acc);
        check("rst_out_valid", out_valid, 0);
        check("rst_c", C, 0);
        check("rst_out_err", out_err, 0);
        rst = 1'b0;
        #1 check("ready_after_rst", in_ready, 1);
        @(negedge clk);

        // Latency: present at edge n, out_valid visible after the second edge.
        A = 32'hDEADBEFF; B = 8'hFF; cfg = 3'd0; in_valid = 1'b1;
        step(acc);
        check("lat_accept", acc, 1);
        in_valid = 1'b0;
        check("lat_not_yet", out_valid, 0);
        step(acc);
        check("lat_valid", out_valid, 1);
        check("lat_single_c", C, 40'h00_0000_FE01);
        check("lat_single_err", out_err, 0);
        step(acc);

        directed("dual", 32'h0000FFFF, 8'hFF, 3'd1, 1'b0, 40'h00_00FE_FF01, 1'b0);
        directed("quad", 32'hFFFFFFFF, 8'hFF, 3'd2, 1'b0, 40'hFE_FFFF_FF01, 1'b0);
        directed("illegal", 32'h12345678, 8'h9A, 3'd3, 1'b0, 40'h0, 1'b1);
        directed("after_ill", 32'h00000003, 8'h05, 3'd0, 1'b0, 40'h0F, 1'b0);
`ifdef MAC_MUL_SIGNED_EN
        directed("sgn_quad", 32'hFFFFFFFF, 8'h02, 3'd2, 1'b1, 40'hFF_FFFF_FFFE, 1'b0);
        directed("sgn_single", 32'h00000080, 8'h80, 3'd0, 1'b1, 40'h00_0000_4000, 1'b0);
`endif

        // Back-to-back quad stream under random backpressure.
        sent = 0; guard = 0;
        A = $urandom; B = 8'($urandom); cfg = 3'd2; sgn = 1'b0; in_valid = 1'b1;
        while (sent < 8 && guard < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            step(acc);
            guard++;
            if (acc) begin
                sent++;
                A = $urandom; B = 8'($urandom);
            end
        end
        check("stream_sent", sent, 8);
        drain();

        // Mixed random traffic: all cfg codes, bubbles and stalls.
        for (int i = 0; i < 150; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            A = $urandom; B = 8'($urandom); cfg = 3'($urandom_range(0, 7));
`ifdef MAC_MUL_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`endif
            step(acc);
        end
        drain();

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send($urandom, 8'($urandom), 3'd2, 1'b0);
        send($urandom, 8'($urandom), 3'd1, 1'b0);
        check("full_occupancy", q.size(), 2);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_c", C, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step(acc);

        // en=0 for three cycles with a full pipeline and out_ready high.
        out_ready = 1'b0;
        send($urandom, 8'($urandom), 3'd0, 1'b0);
        send($urandom, 8'($urandom), 3'd2, 1'b0);
        en = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step(acc);
        in_valid = 1'b0; en = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
